// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder: memory-mapped front end for a byte UART.
// Status and data registers sit at 0x80000000..0x8000000C (exact 32-bit match).
// A single-byte transmit holding register feeds a valid/ready transmitter.
// Receive storage is one holding register by default; defining the macro
// UART_RX_FIFO_EN replaces it with a 4-entry FIFO.
module uart_mmio_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe
);

  localparam logic [31:0] ADDR_TX_STATUS = 32'h8000_0000;
  localparam logic [31:0] ADDR_RX_STATUS = 32'h8000_0004;
  localparam logic [31:0] ADDR_TX_DATA   = 32'h8000_0008;
  localparam logic [31:0] ADDR_RX_DATA   = 32'h8000_000C;

  logic       rd_tx_status;
  logic       rd_rx_status;
  logic       rd_rx_data;
  logic       wr_tx_data;
  logic       tx_empty;
  logic       tx_load;
  logic       tx_fire;
  logic       rx_avail;
  logic       rx_full;
  logic       rx_pop;
  logic       rx_push;
  logic [7:0] rx_head;
  logic       rx_overrun;
  logic [31:0] rd_next;
  // Only the low byte of a store is meaningful; the rest is deliberately ignored.
  logic       unused_wdata_hi;

  assign unused_wdata_hi = ^wdata[31:8];

  assign rd_tx_status = re && (addr == ADDR_TX_STATUS);
  assign rd_rx_status = re && (addr == ADDR_RX_STATUS);
  assign rd_rx_data   = re && (addr == ADDR_RX_DATA);
  assign wr_tx_data   = we && (addr == ADDR_TX_DATA);

  // The holding register is empty exactly when no byte is being offered.
  assign tx_empty = ~tx_valid;
  assign tx_fire  = tx_valid && tx_ready;
  // A store racing a handshake sees the pre-edge full status and is dropped.
  assign tx_load  = wr_tx_data && tx_empty;

  // Transmit holding register: load on an accepted store, release on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (tx_load) begin
      tx_valid <= 1'b1;
      tx_data  <= wdata[7:0];
    end else if (tx_fire) begin
      tx_valid <= 1'b0;
    end
  end

  // A pop frees a slot in the same cycle, so a simultaneous strobe still lands.
  assign rx_pop  = rd_rx_data && rx_avail;
  assign rx_push = rx_strobe && (!rx_full || rx_pop);

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_mem [0:3];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

  assign rx_full  = (count == 3'd4);
  assign rx_avail = (count != 3'd0);
  assign rx_head  = fifo_mem[rd_ptr];

  // FIFO control: 2-bit pointers wrap naturally, count tracks occupancy 0..4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (rx_push) wr_ptr <= wr_ptr + 2'd1;
      if (rx_pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, rx_push} - {2'b00, rx_pop};
    end
  end

  // FIFO storage: payload only, never observed unless count says it is valid.
  always_ff @(posedge clk) begin
    if (rx_push) fifo_mem[wr_ptr] <= rx_data;
  end
`else
  logic [7:0] hold_byte;
  logic       hold_valid;

  assign rx_full  = hold_valid;
  assign rx_avail = hold_valid;
  assign rx_head  = hold_byte;

  // Single holding register occupancy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
    end else if (rx_push) begin
      hold_valid <= 1'b1;
    end else if (rx_pop) begin
      hold_valid <= 1'b0;
    end
  end

  // Holding register payload, qualified by hold_valid.
  always_ff @(posedge clk) begin
    if (rx_push) hold_byte <= rx_data;
  end
`endif

  // Overrun is sticky; a new overrun wins over a clearing status read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun <= 1'b0;
    end else if (rx_strobe && !rx_push) begin
      rx_overrun <= 1'b1;
    end else if (rd_rx_status) begin
      rx_overrun <= 1'b0;
    end
  end

  // Read mux built from pre-edge state; unmapped and empty reads give zero.
  always_comb begin
    rd_next = 32'h0000_0000;
    if (rd_tx_status) begin
      rd_next = {31'b0, tx_empty};
    end else if (rd_rx_status) begin
      rd_next = {30'b0, rx_overrun, rx_avail};
    end else if (rd_rx_data && rx_avail) begin
      rd_next = {24'b0, rx_head};
    end
  end

  // Load data register: captured on every load, held between loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'h0000_0000;
    end else if (re) begin
      rdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Bench for uart_mmio_responder: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based behavioural model.
module tb_uart_mmio_responder;

  localparam logic [31:0] A_TXST = 32'h8000_0000;
  localparam logic [31:0] A_RXST = 32'h8000_0004;
  localparam logic [31:0] A_TXD  = 32'h8000_0008;
  localparam logic [31:0] A_RXD  = 32'h8000_000C;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_strobe;

  uart_mmio_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .re        (re),
    .rdata     (rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_strobe (rx_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  bit          m_tx_full;
  logic [7:0]  m_tx_byte;
  bit          m_ovr;
  logic [31:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_tx_full = 0;
    m_tx_byte = 8'h00;
    m_ovr     = 0;
    m_rdata   = 32'h0;
  endtask

  // One clock: drive inputs, advance the model across the edge, compare outputs.
  task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic w,
                       input logic r, input logic txr, input logic [7:0] rxd,
                       input logic rxs);
    bit was_full;
    bit pop;
    addr = a; wdata = wd; we = w; re = r; tx_ready = txr; rx_data = rxd; rx_strobe = rxs;
    @(posedge clk);
    was_full = m_tx_full;
    if (r) begin
      if (a == A_TXST)      m_rdata = {31'b0, !was_full};
      else if (a == A_RXST) m_rdata = {30'b0, m_ovr, m_q.size() != 0};
      else if (a == A_RXD)  m_rdata = (m_q.size() != 0) ? {24'b0, m_q[0]} : 32'h0;
      else                  m_rdata = 32'h0;
    end
    pop = r && (a == A_RXD) && (m_q.size() != 0);
    if (was_full && txr) m_tx_full = 0;
    if (w && (a == A_TXD) && !was_full) begin
      m_tx_full = 1;
      m_tx_byte = wd[7:0];
    end
    if (pop) void'(m_q.pop_front());
    if (rxs && m_q.size() >= DEPTH) m_ovr = 1;
    else if (r && (a == A_RXST)) m_ovr = 0;
    if (rxs && m_q.size() < DEPTH) m_q.push_back(rxd);
    #1;
    chk("rdata", rdata, m_rdata);
    chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_tx_full});
    chk("tx_data", {24'b0, tx_data}, {24'b0, m_tx_byte});
  endtask

  task automatic idle(input logic txr);
    cycle(32'h0, 32'h0, 1'b0, 1'b0, txr, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(a, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic strobe(input logic [7:0] b);
    cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, b, 1'b1);
  endtask

  // Called just after a rising edge; asserts reset asynchronously mid-cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
    model_reset();
    addr = 32'h0; wdata = 32'h0; we = 0; re = 0; tx_ready = 0; rx_data = 0; rx_strobe = 0;
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 6))
      0: return A_TXST;
      1: return A_RXST;
      2: return A_TXD;
      3: return A_RXD;
      4: return 32'h8000_0010;
      5: return 32'h0000_0008;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    addr = 32'h0; wdata = 32'h0; we = 0; re = 0; tx_ready = 0; rx_data = 0; rx_strobe = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Reset state and transmit status
    rd(A_TXST);
    chk("txst_after_reset", rdata, 32'h1);
    chk("txv_after_reset", {31'b0, tx_valid}, 32'h0);
    rd(A_RXST);
    chk("rxst_after_reset", rdata, 32'h0);

    // Held byte stays stable under back-pressure; second store dropped
    cycle(A_TXD, 32'hFFFF_FF41, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (5) begin
      idle(1'b0);
      chk("tx_hold", {24'b0, tx_data}, 32'h41);
    end
    cycle(A_TXD, 32'h0000_0042, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("tx_drop", {24'b0, tx_data}, 32'h41);
    idle(1'b1);
    chk("tx_hs_valid", {31'b0, tx_valid}, 32'h0);
    rd(A_TXST);
    chk("tx_empty_after_hs", rdata, 32'h1);
    // Store in the same cycle as a handshake is dropped
    cycle(A_TXD, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(A_TXD, 32'h0000_0020, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("tx_race_drop", {31'b0, tx_valid}, 32'h0);
    // Store to a read-only address does nothing
    cycle(A_TXST, 32'h0000_0033, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("ro_store", {31'b0, tx_valid}, 32'h0);

    // Single byte receive path
    @(posedge clk); #1; do_reset();
    strobe(8'h55);
    rd(A_RXST);
    chk("rx_avail", rdata, 32'h1);
    rd(A_RXD);
    chk("rx_byte", rdata, 32'h55);
    rd(A_RXST);
    chk("rx_empty", rdata, 32'h0);
    rd(A_RXD);
    chk("rx_empty_pop", rdata, 32'h0);
    rd(32'h1234_5678);
    chk("unmapped", rdata, 32'h0);

`ifdef UART_RX_FIFO_EN
    @(posedge clk); #1; do_reset();
    for (int i = 1; i <= 5; i++) strobe(8'(i));
    rd(A_RXST);
    chk("fifo_ovr_status", rdata, 32'h3);
    for (int i = 1; i <= 5; i++) begin
      rd(A_RXD);
      chk("fifo_pop", rdata, (i <= 4) ? i : 0);
    end
    rd(A_RXST);
    chk("fifo_status2", rdata, 32'h0);
`else
    @(posedge clk); #1; do_reset();
    strobe(8'hAA);
    cycle(A_RXD, 32'h0, 1'b0, 1'b1, 1'b0, 8'hBB, 1'b1);
    chk("hold_pop_race", rdata, 32'hAA);
    rd(A_RXD);
    chk("hold_pop_next", rdata, 32'hBB);
    rd(A_RXST);
    chk("hold_no_ovr", rdata, 32'h0);
    // Overrun concurrent with a status read stays set
    strobe(8'h01);
    cycle(A_RXST, 32'h0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b1);
    chk("ovr_race_ret", rdata, 32'h1);
    rd(A_RXST);
    chk("ovr_race_sticky", rdata, 32'h3);
`endif

    // Reset while a byte is pending and rx data is held
    cycle(A_TXD, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    strobe(8'h11);
    strobe(8'h22);
    chk("pre_rst_txv", {31'b0, tx_valid}, 32'h1);
    do_reset();
    rd(A_RXST);
    chk("post_rst_rxst", rdata, 32'h0);

    // Randomized traffic against the model, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cycle(pick_addr(), $urandom(), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4),
              ($urandom_range(0, 9) < 3), 8'($urandom()), ($urandom_range(0, 9) < 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mmio_responder.md
UART_MMIO_RESPONDER -- requirements
Module: uart_mmio_responder

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port addr, input, 32 bits: CPU load/store address, full 32-bit exact match.
REQ-004 The block SHALL have port wdata, input, 32 bits: store data; only bits [7:0] are used.
REQ-005 The block SHALL have port we, input, 1 bit: store strobe, one cycle per store.
REQ-006 The block SHALL have port re, input, 1 bit: load strobe, one cycle per load.
REQ-007 The block SHALL have port rdata, output, 32 bits: registered load data.
REQ-008 The block SHALL have port tx_data, output, 8 bits: byte to the serial transmitter.
REQ-009 The block SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-010 The block SHALL have port tx_ready, input, 1 bit: the transmitter accepts a byte when tx_valid and tx_ready are both high.
REQ-011 The block SHALL have port rx_data, input, 8 bits: received byte.
REQ-012 The block SHALL have port rx_strobe, input, 1 bit: one-cycle pulse meaning rx_data holds a new byte; there is no back-pressure.

Function
REQ-013 The register map SHALL be:
- 0x80000000 read: bit0 = tx_empty (DataInReady).
- 0x80000004 read: bit0 = rx_avail (DataOutValid), bit1 = rx_overrun.
- 0x80000008 write: transmit byte, wdata[7:0].
- 0x8000000C read: received byte in bits [7:0]; the read pops it.
REQ-014 rdata SHALL update on the edge after re is sampled high, and SHALL hold that value until the next re.
REQ-015 For any read, unused rdata bits SHALL be zero.
REQ-016 A read of an unmapped address SHALL return 0.
REQ-017 Stores to read-only or unmapped addresses SHALL have no effect.
REQ-018 A store to 0x80000008 with tx_empty=1 SHALL do the following:
- latch wdata[7:0] into tx_data;
- on the following edge, set tx_valid=1 and tx_empty=0.
REQ-019 A store to 0x80000008 with tx_empty=0 SHALL be silently dropped; the held byte is unchanged.
REQ-020 tx_valid and tx_data SHALL stay stable until the handshake (tx_valid && tx_ready) is sampled high.
REQ-021 When the handshake completes, tx_valid SHALL clear and tx_empty SHALL set on that same edge.
REQ-022 If a store to 0x80000008 and a handshake completion occur in the same cycle, the handshake SHALL complete and the store SHALL be dropped, because the status was full when sampled.
REQ-023 A rx_strobe with free storage SHALL write rx_data into storage and set rx_avail=1 on the next edge.
REQ-024 A rx_strobe with storage full SHALL drop the byte and set rx_overrun=1; stored bytes are unchanged.
REQ-025 A read of 0x8000000C with rx_avail=1 SHALL return the oldest byte and remove it from storage.
REQ-026 A read of 0x8000000C with rx_avail=0 SHALL return 0 and change no state.
REQ-027 If rx_strobe and a pop of 0x8000000C occur in the same cycle, both SHALL take effect:
- the pop returns the oldest byte;
- the new byte is stored;
- full-storage case: the strobe counts as not overrunning.
REQ-028 A read of 0x80000004 SHALL clear rx_overrun on the same edge that captures rdata; rdata returns the pre-clear value.
REQ-029 If an overrun event and a read of 0x80000004 occur in the same cycle, rx_overrun SHALL remain 1.
REQ-030 If re and we are asserted in the same cycle, both SHALL be processed independently.

Reset
REQ-031 While rst_n=0, all of the following SHALL hold: rdata=0, tx_data=0, tx_valid=0, tx_empty=1, rx_avail=0, rx_overrun=0, and rx storage pointers and count = 0.
REQ-032 A reset asserted mid-transfer SHALL abort any pending tx byte (tx_valid drops asynchronously) and discard all rx bytes.
REQ-033 The first store or strobe SHALL be honoured on the first rising edge after rst_n rises.

Configuration
REQ-034 With macro UART_RX_FIFO_EN defined, rx storage SHALL be a 4-entry FIFO, as follows:
- Full means count = 4.
- Pointers are 2 bits wide and wrap from 3 to 0.
- rx_avail = (count != 0).
REQ-035 With UART_RX_FIFO_EN undefined, rx storage SHALL be a single holding register, full when rx_avail=1; all other behaviour is identical.

Verification
REQ-036 Reset, then read 0x80000000 -> rdata=0x00000001 one cycle later; tx_valid=0.
REQ-037 Store 0x41 to 0x80000008 with tx_ready=0 for 5 cycles, store 0x42, then pulse tx_ready -> tx_data=0x41 stable throughout; 0x42 dropped; tx_empty=1 after the handshake.
REQ-038 Strobe rx_data=0x55, then read 0x80000004, then 0x8000000C, then 0x80000004 -> reads return 0x1, 0x55, 0x0.
REQ-039 With FIFO enabled, strobe 0x01..0x05, then read 0x8000000C five times -> returns 0x01..0x04 then 0; the first read of 0x80000004 returns 0x3 and the second returns 0x1 or 0x0 as applicable.
REQ-040 With FIFO disabled, strobe 0xAA, then 0xBB in the same cycle as a pop -> pop returns 0xAA; next pop returns 0xBB; rx_overrun=0.
REQ-041 Assert rst_n=0 while tx_valid=1 and 2 rx bytes are held -> tx_valid=0 immediately; after release, 0x80000004 reads 0.
